// File: rtl/fxp_do_all_ops.sv
// Combined fixed-point lane unit: Q2.14 operand A and Q4.12 operand B give a
// registered Q4.12 sum, difference and saturated product, plus carry/borrow flags.
module fxp_do_all_ops (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] q2_14,
  input  logic [15:0] q4_12,
  output logic [15:0] sum_res,
  output logic [15:0] diff_res,
  output logic [15:0] multi_res,
  output logic        cout,
  output logic        borrow_res
);

  logic [15:0] a_al;
  logic [16:0] sum17;
  logic [16:0] diff17;
  logic [17:0] p_top;
  logic        mul_ovf;

  logic [15:0] sum_d, sum_q;
  logic [15:0] diff_d, diff_q;
  logic [15:0] mul_d, mul_q;
  logic        cout_d, cout_q;
  logic        borrow_d, borrow_q;

  // Q2.14 -> Q4.12 by arithmetic shift; dropping two LSBs rounds toward -inf.
  assign a_al = {{2{q2_14[15]}}, q2_14[15:2]};

  assign sum17 = {1'b0, a_al} + {1'b0, q4_12};

  // Bit 16 of the zero-extended difference is set exactly when a_al < q4_12 (unsigned).
  assign diff17 = {1'b0, a_al} - {1'b0, q4_12};

  // Full Q6.26 product shifted down to keep P[31:14]: [15:0] is the Q4.12 result,
  // [17:15] = P[31:29] must agree for the result to fit.
  assign p_top = 18'((32'(signed'(q2_14)) * 32'(signed'(q4_12))) >>> 14);

  assign mul_ovf = !((p_top[17:15] == 3'b000) || (p_top[17:15] == 3'b111));

  always_comb begin
    sum_d    = sum17[15:0];
    cout_d   = sum17[16];
    diff_d   = diff17[15:0];
    borrow_d = diff17[16];
    mul_d    = p_top[15:0];
    if (mul_ovf) begin
      mul_d = p_top[17] ? 16'h8000 : 16'h7FFF;
    end
  end

  // NOTE: non-blocking assignments so every output register captures the same
  // pre-edge operand pair; data and flags can never land on different edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= 16'h0000;
      diff_q   <= 16'h0000;
      mul_q    <= 16'h0000;
      cout_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      mul_q    <= mul_d;
      cout_q   <= cout_d;
      borrow_q <= borrow_d;
    end
  end

  assign sum_res    = sum_q;
  assign diff_res   = diff_q;
  assign multi_res  = mul_q;
  assign cout       = cout_q;
  assign borrow_res = borrow_q;

endmodule

// File: tb/tb_fxp_do_all_ops.sv
// Scoreboard bench for fxp_do_all_ops: stimulus pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares them.
module tb_fxp_do_all_ops;

  typedef struct packed {
    logic [15:0] sum;
    logic [15:0] diff;
    logic [15:0] mul;
    logic        cout;
    logic        borrow;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic [15:0] sum_res;
  logic [15:0] diff_res;
  logic [15:0] multi_res;
  logic        cout;
  logic        borrow_res;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  fxp_do_all_ops dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q2_14      (a_i),
    .q4_12      (b_i),
    .sum_res    (sum_res),
    .diff_res   (diff_res),
    .multi_res  (multi_res),
    .cout       (cout),
    .borrow_res (borrow_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".sum"},    sum_res,           16'h0000);
    check({tag, ".diff"},   diff_res,          16'h0000);
    check({tag, ".mul"},    multi_res,         16'h0000);
    check({tag, ".cout"},   {15'd0, cout},       16'h0000);
    check({tag, ".borrow"}, {15'd0, borrow_res}, 16'h0000);
  endtask

  // Floor division for positive divisors.
  function automatic longint floor_div(input longint x, input longint d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  // Reference model from the arithmetic rules using plain integers.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    longint ai   = longint'(signed'(a));
    longint bi   = longint'(signed'(b));
    longint a_al = floor_div(ai, 4);
    longint au   = (a_al + 65536) % 65536;
    longint bu   = longint'(b);
    longint s    = au + bu;
    longint q    = floor_div(ai * bi, 16384);
    res_t   r;
    r.sum    = 16'(s % 65536);
    r.cout   = (s >= 65536);
    r.diff   = 16'((au - bu + 65536) % 65536);
    r.borrow = (au < bu);
    if (q > 32767)       r.mul = 16'h7FFF;
    else if (q < -32768) r.mul = 16'h8000;
    else                 r.mul = 16'((q + 65536) % 65536);
    return r;
  endfunction

  // Drive a pair away from the edge, let it be sampled, record the expectation.
  task automatic apply(input logic [15:0] a, input logic [15:0] b);
    a_i = a;
    b_i = b;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corners [8] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000,
                                 16'h0001, 16'h4000, 16'hC000, 16'h1000};
    if ($urandom_range(3) == 0) return corners[$urandom_range(7)];
    return 16'($urandom);
  endfunction

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    res_t exp;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        exp = sb.pop_front();
        check("sum",    sum_res,             exp.sum);
        check("diff",   diff_res,            exp.diff);
        check("mul",    multi_res,           exp.mul);
        check("cout",   {15'd0, cout},       {15'd0, exp.cout});
        check("borrow", {15'd0, borrow_res}, {15'd0, exp.borrow});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dir_a [6] = '{16'hC000, 16'h2000, 16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF};
    logic [15:0] dir_b [6] = '{16'h1000, 16'h3000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hFFFF};

    rst_n = 1'b1;
    a_i   = 16'h0000;
    b_i   = 16'h0000;
    #1 rst_n = 1'b0;

    // Outputs stay cleared across edges while reset is held and inputs move.
    repeat (3) begin
      @(negedge clk);
      a_i = 16'($urandom);
      b_i = 16'($urandom);
      #1 check_zero("rst_hold");
    end

    @(negedge clk);
    a_i = 16'h4000;
    b_i = 16'h1000;
    #1 rst_n = 1'b1;
    apply(16'h4000, 16'h1000);

    foreach (dir_a[i]) apply(dir_a[i], dir_b[i]);

    for (int i = 0; i < 150; i++) apply(pick_operand(), pick_operand());

    // Asynchronous reset between edges drops the in-flight result immediately.
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      a_i = 16'($urandom);
      b_i = 16'($urandom);
      #1 check_zero("rst_hold2");
    end
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 150; i++) apply(pick_operand(), pick_operand());

    @(negedge clk);
    #1 check("sb_drain", 16'(sb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
